// File: rtl/main_control_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package main_control_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU op codes handed to the ALU control block
    localparam logic [2:0] UC_ADD   = 3'b000;
    localparam logic [2:0] UC_SLT   = 3'b010;
    localparam logic [2:0] UC_AND   = 3'b101;
    localparam logic [2:0] UC_OR    = 3'b110;
    localparam logic [2:0] UC_RTYPE = 3'b111;

    // PC source mux selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand B mux selects
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_WB_R,
        ST_EXEC_I,
        ST_WB_I,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_BRANCH,
        ST_JUMP,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_ILLEGAL
    } op_class_e;

    // Every datapath control the FSM drives from its state register.
    typedef struct packed {
        logic [2:0] uc;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_srca;
        logic [1:0] alu_srcb;
        logic       halted;
    } ctrl_t;

    // Moore output table: controls for a given state. iuc is the I-type ALU
    // op captured at decode; it only matters in EXEC_I.
    function automatic ctrl_t state_ctrl(state_e st, logic [2:0] iuc);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.mem_read = 1'b1;
                c.alu_srcb = SRCB_FOUR;
                c.uc       = UC_ADD;
            end
            ST_DECODE: begin
                // Branch target computed speculatively into ALUOut
                c.alu_srcb = SRCB_IMM_SH2;
                c.uc       = UC_ADD;
            end
            ST_EXEC_R: begin
                c.alu_srca = 1'b1;
                c.alu_srcb = SRCB_B;
                c.uc       = UC_RTYPE;
            end
            ST_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_EXEC_I: begin
                c.alu_srca = 1'b1;
                c.alu_srcb = SRCB_IMM;
                c.uc       = iuc;
            end
            ST_WB_I: begin
                c.reg_write = 1'b1;
            end
            ST_MEM_ADDR: begin
                c.alu_srca = 1'b1;
                c.alu_srcb = SRCB_IMM;
                c.uc       = UC_ADD;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_srca      = 1'b1;
                c.pc_write_cond = 1'b1;
                c.pc_src        = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PCSRC_JUMP;
            end
            ST_HALT: begin
                c.halted = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/main_control_opcode_decode.sv
// Combinational opcode classifier: opcode -> instruction class and I-type ALU op.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the FSM samples the outputs only in DECODE.
module opcode_decode
    import main_control_pkg::*;
(
    input  logic [5:0] opcode_i,
    output op_class_e  op_class_o,
    output logic [2:0] iuc_o
);

    // Map each supported opcode to its class; anything unrecognised is illegal.
    always_comb begin
        op_class_o = CLS_ILLEGAL;
        iuc_o      = UC_ADD;
        case (opcode_i)
            OP_RTYPE: op_class_o = CLS_R;
            OP_ADDI: begin
                op_class_o = CLS_I;
                iuc_o      = UC_ADD;
            end
            OP_ANDI: begin
                op_class_o = CLS_I;
                iuc_o      = UC_AND;
            end
            OP_ORI: begin
                op_class_o = CLS_I;
                iuc_o      = UC_OR;
            end
            OP_SLTI: begin
                op_class_o = CLS_I;
                iuc_o      = UC_SLT;
            end
            OP_LW:   op_class_o = CLS_LW;
            OP_SW:   op_class_o = CLS_SW;
            OP_BEQ:  op_class_o = CLS_BEQ;
            OP_J:    op_class_o = CLS_J;
            default: op_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/main_control.sv
// Multi-cycle MIPS main control FSM; optional illegal-opcode trap via MAIN_CONTROL_ILLEGAL_TRAP_EN.
// Latency: 3 (BEQ/J), 4 (R/I/SW), 5 (LW) cycles per instruction with mem_ready held high.
// Backpressure: FETCH, MEM_RD and MEM_WR hold with stable strobes while mem_ready is low.
module main_control
    import main_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       rs_eq_rt,
    input  logic       mem_ready,
    output logic [2:0] uc,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic       halted
);

    state_e     state_q, state_d;
    op_class_e  class_q, class_d;
    logic [2:0] iuc_q, iuc_d;
    ctrl_t      ctrl_q;
    op_class_e  dec_class;
    logic [2:0] dec_iuc;
    logic       fetch_done;

    // The equality flag gates the PC load inside the datapath, not here.
    logic unused_rs_eq_rt;
    assign unused_rs_eq_rt = rs_eq_rt;

    opcode_decode u_opcode_decode (
        .opcode_i   (opcode),
        .op_class_o (dec_class),
        .iuc_o      (dec_iuc)
    );

    // Class and I-type ALU op are captured in DECODE so a later IR change is ignored.
    assign class_d = (state_q == ST_DECODE) ? dec_class : class_q;
    assign iuc_d   = (state_q == ST_DECODE) ? dec_iuc   : iuc_q;

    // Next-state sequencing through fetch, decode, execute, memory and write-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (dec_class)
                    CLS_R:   state_d = ST_EXEC_R;
                    CLS_I:   state_d = ST_EXEC_I;
                    CLS_LW,
                    CLS_SW:  state_d = ST_MEM_ADDR;
                    CLS_BEQ: state_d = ST_BRANCH;
                    CLS_J:   state_d = ST_JUMP;
`ifdef MAIN_CONTROL_ILLEGAL_TRAP_EN
                    default: state_d = ST_HALT;
`else
                    // Unknown opcode retires as a NOP
                    default: state_d = ST_FETCH;
`endif
                endcase
            end
            ST_EXEC_R:   state_d = ST_WB_R;
            ST_WB_R:     state_d = ST_FETCH;
            ST_EXEC_I:   state_d = ST_WB_I;
            ST_WB_I:     state_d = ST_FETCH;
            ST_MEM_ADDR: state_d = (class_q == CLS_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_d = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   state_d = ST_FETCH;
            ST_MEM_WR:   state_d = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_FETCH;
        endcase
    end

    // State register plus registered Moore outputs decoded from the next state,
    // so the outputs always line up with state_q; reset lands directly in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            class_q <= CLS_ILLEGAL;
            iuc_q   <= UC_ADD;
            ctrl_q  <= state_ctrl(ST_FETCH, UC_ADD);
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            iuc_q   <= iuc_d;
            ctrl_q  <= state_ctrl(state_d, iuc_d);
        end
    end

    // The instruction word and PC+4 are committed in the single FETCH cycle
    // where memory completes, giving exactly one pulse per instruction.
    assign fetch_done = (state_q == ST_FETCH) && mem_ready;

    assign uc            = ctrl_q.uc;
    assign pc_write      = ctrl_q.pc_write | fetch_done;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign pc_src        = ctrl_q.pc_src;
    assign ir_write      = fetch_done;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign iord          = ctrl_q.iord;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign alu_srca      = ctrl_q.alu_srca;
    assign alu_srcb      = ctrl_q.alu_srcb;

`ifdef MAIN_CONTROL_ILLEGAL_TRAP_EN
    assign halted = ctrl_q.halted;
`else
    // HALT is unreachable without the trap, so the flag is tied low.
    logic unused_halted_q;
    assign unused_halted_q = ctrl_q.halted;
    assign halted          = 1'b0;
`endif

endmodule

// File: doc/main_control.md
# main_control

Multi-cycle main control FSM for the MIPS core. Decodes the 6-bit opcode from the instruction register and sequences fetch, decode, execute, memory and write-back. Generates every datapath enable and mux select. Drives the 3-bit `uc` code consumed by the ALU control block, which turns `uc` plus `funct` into the ALU select.

## Interface
- Parameters: none.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; sampled in DECODE.
- `rs_eq_rt`  in  1  datapath equality comparator (A == B).
- `mem_ready`  in  1  unified memory has completed the current access this cycle.
- `uc`  out  3  ALU op to ALU control: 111 R-type (funct decides), 000 add, 101 AND, 010 SLT, 110 OR.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if `rs_eq_rt`.
- `pc_src`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `ir_write`  out  1  IR load.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `iord`  out  1  0 = PC address, 1 = ALUOut address.
- `reg_write`  out  1  register file write.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR.
- `alu_srca`  out  1  0 = PC, 1 = A.
- `alu_srcb`  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `halted`  out  1  illegal-opcode halt flag (constant 0 without the macro).

## Operation
- Moore FSM. All outputs are decoded from the state register only. Outputs not listed for a state are 0.
- FETCH: `mem_read`, `alu_srcb`=01, `uc`=000.
  - Stay in FETCH while `mem_ready`=0.
  - When `mem_ready`=1, also assert `ir_write` and `pc_write` in the same cycle, then go to DECODE.
- DECODE: `alu_srcb`=11, `uc`=000 (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC_R.
  - 001000/001100/001101/001010 → EXEC_I.
  - 100011/101011 → MEM_ADDR.
  - 000100 → BRANCH.
  - 000010 → JUMP.
  - anything else → ILLEGAL handling (see Configuration).
- EXEC_R: `alu_srca`=1, `alu_srcb`=00, `uc`=111 → WB_R.
- WB_R: `reg_write`, `reg_dst`=1 → FETCH.
- EXEC_I: `alu_srca`=1, `alu_srcb`=10. `uc` by opcode: ADDI 000, ANDI 101, SLTI 010, ORI 110 → WB_I.
- WB_I: `reg_write`, `reg_dst`=0 → FETCH.
- MEM_ADDR: `alu_srca`=1, `alu_srcb`=10, `uc`=000 → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: `mem_read`, `iord`. Wait for `mem_ready`, then → MEM_WB.
- MEM_WB: `reg_write`, `mem_to_reg`, `reg_dst`=0 → FETCH.
- MEM_WR: `mem_write`, `iord`. Wait for `mem_ready`, then → FETCH.
- BRANCH: `alu_srca`=1, `pc_write_cond`, `pc_src`=01 → FETCH.
- JUMP: `pc_write`, `pc_src`=10 → FETCH.
- The opcode class is latched in DECODE. EXEC_I/MEM_ADDR use the latched class, so an IR change after DECODE has no effect.

## Timing
- Reset (async assert, sync release): state = FETCH. Outputs immediately show the FETCH values: `mem_read`=1, `alu_srcb`=01, all others 0, `halted`=0.
- Reset mid-instruction aborts it; no further `reg_write` or `mem_write` is issued.
- Cycles per instruction with `mem_ready` held 1:
  - R-type, I-arith, SW: 4.
  - LW: 5.
  - BEQ, J: 3.
- Each cycle of `mem_ready`=0 in FETCH/MEM_RD/MEM_WR adds exactly one cycle. Strobes stay stable while waiting.
- `pc_write` and `ir_write` are asserted for exactly one cycle per instruction.

## Configuration
- `MAIN_CONTROL_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE → HALT.
  - In HALT, all strobes are 0 and `halted`=1 until reset.
- Not defined:
  - An unknown opcode is a NOP: DECODE → FETCH.
  - `halted` is tied to 0.

## Structure
- `main_control_pkg`: opcode localparams, `uc` code localparams, state enum, opcode-class enum.
- Sub-module `opcode_decode` (combinational): opcode → class and I-type `uc`. Instantiated once; its outputs are latched in DECODE.

## Test plan
- ADD (opcode 000000), `mem_ready`=1 → `uc`=111 in cycle 3, `reg_write` with `reg_dst`=1 in cycle 4, FETCH in cycle 5.
- ORI (001101) → `uc`=110 with `alu_srcb`=10 in EXEC_I; SLTI (001010) → `uc`=010; ANDI → 101; ADDI → 000.
- LW with `mem_ready` low for 3 cycles in MEM_RD → `mem_read`/`iord` held for 4 cycles, then MEM_WB with `mem_to_reg`=1; total 8 cycles.
- BEQ with `rs_eq_rt`=1 and then with `rs_eq_rt`=0 → `pc_write_cond`=1, `pc_src`=01 in cycle 3 in both cases; 3-cycle latency.
- Opcode 111111 → with the macro, `halted`=1 and no strobes until `rst_n` low; without the macro, FETCH in cycle 3 and no `reg_write`.
- `rst_n` pulsed low during MEM_WR → state FETCH immediately, `mem_write`=0 in the same cycle.
